// File: rtl/rng_pkg.sv
// Shared types and helpers for the range sampler: FSM states, mask computation, count width.
package rng_pkg;

    localparam int unsigned RNG_WIDTH = 8;
    localparam int unsigned RNG_DEPTH = 4;
    localparam int unsigned RNG_CNT_W = $clog2(RNG_DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } state_e;

    // Smallest 2^k-1 >= n-1; computed on 32 bits so any sampler width up to 32 can use it.
    function automatic int unsigned range_mask(input int unsigned n);
        int unsigned m;
        m = 0;
        for (int i = 0; i < 32; i++) begin
            if (n != 0 && m < n - 1) begin
                m = (m << 1) | 32'd1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// Show-ahead FIFO: head entry is visible on data_o whenever the FIFO is non-empty, 0 otherwise.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH = RNG_WIDTH,
    parameter int unsigned DEPTH = RNG_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: empty FIFO masks the head to 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rand_range_sampler.sv
// Turns free-running LFSR bytes into uniform values in [0, N-1] via mask-and-reject with bounded retries.
module rand_range_sampler
    import rng_pkg::*;
#(
    parameter int unsigned WIDTH     = RNG_WIDTH,
    parameter int unsigned DEPTH     = RNG_DEPTH,
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           rnd_in,
    input  logic [WIDTH-1:0]           range_max,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       range_err,
    output logic                       lfsr_stuck
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d, mask_q, mask_d, prev_q;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             range_err_q, range_err_d, stuck_q;
    logic [WIDTH-1:0] cand, push_data, new_mask;
    logic             push, fifo_full, fifo_empty;

    assign cand     = rnd_in & mask_q;
    assign new_mask = WIDTH'(range_mask(32'(range_max)));

    // Next-state and sampling decisions; reload points latch range_max and its mask.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        mask_d      = mask_q;
        tries_d     = tries_q;
        range_err_d = range_err_q;
        push        = 1'b0;
        push_data   = '0;
        case (state_q)
            IDLE: begin
                if (enable && range_max == '0) begin
                    range_err_d = 1'b1;
                end else if (enable && !fifo_full) begin
                    range_err_d = 1'b0;
                    n_d         = range_max;
                    mask_d      = new_mask;
                    tries_d     = '0;
                    state_d     = SAMPLE;
                end
            end
            SAMPLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    tries_d = '0;
                end else if (fifo_full) begin
                    state_d = IDLE;
                end else if (cand < n_q) begin
                    push      = 1'b1;
                    push_data = cand;
                    tries_d   = '0;
                    n_d       = range_max;
                    mask_d    = new_mask;
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    // cand < 2*n_q, so the folded value is always in range
                    push      = 1'b1;
                    push_data = cand - n_q;
                    tries_d   = '0;
                    n_d       = range_max;
                    mask_d    = new_mask;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            mask_q      <= '0;
            tries_q     <= '0;
            prev_q      <= '0;
            range_err_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            mask_q      <= mask_d;
            tries_q     <= tries_d;
            prev_q      <= rnd_in;
            range_err_q <= range_err_d;
            if (state_q == SAMPLE && rnd_in == prev_q) begin
                stuck_q <= 1'b1;
            end
        end
    end

    rng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign range_err  = range_err_q;
    assign lfsr_stuck = stuck_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler: accept/reject, fallback, backpressure, range error, lockup, reset.
module tb_rand_range_sampler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] rnd_in;
    logic [7:0] range_max;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       range_err;
    logic       lfsr_stuck;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rand_range_sampler dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rnd_in     (rnd_in),
        .range_max  (range_max),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .range_err  (range_err),
        .lfsr_stuck (lfsr_stuck)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One directed step: drive rnd_in, advance one clock.
    task automatic step(input logic [7:0] r);
        rnd_in = r;
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rnd_in = 8'h00; range_max = 8'h00; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(range_err), 32'd0);
        chk("rst_stuck", 32'(lfsr_stuck), 32'd0);
        reset = 1'b0;

        // Basic accept/reject, N=6 (mask 7)
        range_max = 8'd6; out_ready = 1'b1; enable = 1'b1;
        step(8'h40);
        step(8'h05);
        chk("basic_v1", 32'(out_valid), 32'd1);
        chk("basic_d1", 32'(out_data), 32'd5);
        step(8'h0E);
        chk("basic_rej6", 32'(out_valid), 32'd0);
        step(8'h0F);
        chk("basic_rej7", 32'(out_valid), 32'd0);
        step(8'h13);
        chk("basic_d2", 32'(out_data), 32'd3);
        chk("basic_c2", 32'(fifo_count), 32'd1);
        enable = 1'b0;
        step(8'h50);
        chk("basic_drain", 32'(fifo_count), 32'd0);

        // Fallback after MAX_TRIES rejects: 7,7,7,6 -> 6-6 = 0
        out_ready = 1'b0; enable = 1'b1;
        step(8'h51);
        step(8'h07);
        step(8'h0F);
        step(8'h17);
        chk("fb_none", 32'(fifo_count), 32'd0);
        step(8'h1E);
        chk("fb_valid", 32'(out_valid), 32'd1);
        chk("fb_data", 32'(out_data), 32'd0);
        chk("fb_count", 32'(fifo_count), 32'd1);
        chk("fb_stuck", 32'(lfsr_stuck), 32'd0);
        enable = 1'b0; out_ready = 1'b1;
        step(8'h60);
        chk("fb_drain", 32'(fifo_count), 32'd0);

        // Full / backpressure with N=1
        out_ready = 1'b0; range_max = 8'd1; enable = 1'b1;
        step(8'h61);
        step(8'h62);
        step(8'h63);
        step(8'h64);
        step(8'h65);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_data", 32'(out_data), 32'd0);
        step(8'h66);
        step(8'h67);
        chk("full_hold", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        step(8'h68);
        chk("full_pop", 32'(fifo_count), 32'd3);
        out_ready = 1'b0;
        step(8'h69);
        chk("full_idle2sample", 32'(fifo_count), 32'd3);
        step(8'h6A);
        chk("full_resume", 32'(fifo_count), 32'd4);
        enable = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(8'(8'h6B + i));
        chk("full_drain", 32'(fifo_count), 32'd0);

        // range_max==0 is flagged, then cleared by a legal range
        enable = 1'b1; range_max = 8'd0;
        step(8'h71);
        chk("err_set", 32'(range_err), 32'd1);
        step(8'h72);
        chk("err_nopush", 32'(out_valid), 32'd0);
        chk("err_hold", 32'(range_err), 32'd1);
        range_max = 8'd10;
        step(8'h70);
        chk("err_clr", 32'(range_err), 32'd0);
        range_max = 8'd16;
        step(8'h03);
        chk("err_sample", 32'(out_data), 32'd3);

        // Lockup: 0xFF held two cycles in SAMPLE with N=16
        step(8'hFF);
        chk("lock_pre", 32'(lfsr_stuck), 32'd0);
        chk("lock_d15", 32'(out_data), 32'd15);
        step(8'hFF);
        chk("lock_set", 32'(lfsr_stuck), 32'd1);
        step(8'h12);
        step(8'h34);
        chk("lock_sticky", 32'(lfsr_stuck), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step(8'(8'h80 + i));
        chk("lock_drain", 32'(fifo_count), 32'd0);

        // Async reset with two entries held
        out_ready = 1'b0; range_max = 8'd5; enable = 1'b1;
        step(8'h90);
        step(8'h01);
        step(8'h02);
        enable = 1'b0;
        chk("mid_count", 32'(fifo_count), 32'd2);
        chk("mid_head", 32'(out_data), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_stuck", 32'(lfsr_stuck), 32'd0);
        tick();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
